program_loader: RTL and testbench
=================================

# program_loader

Byte-serial program loader that fills instruction memory before execution starts. It sits upstream of the instruction-fetch stage and is the write side of the program-loading handshake. It accepts a length-prefixed big-endian byte stream, assembles 32-bit instruction words, and issues one write strobe per word at sequential word addresses. It raises `programLoaded` once the image is committed, or `loadError` if the transfer is malformed or stalls.

## Interface
Parameters:
- `ADDR_WIDTH`, default 8: word-address width; capacity is 2^ADDR_WIDTH words.
- `TIMEOUT_CYCLES`, default 1024: maximum idle cycles between bytes before the load is aborted.

Ports:
- `clock`  input  1  single clock; all logic is rising-edge.
- `reset`  input  1  synchronous, active-high.
- `startProgramLoading`  input  1  level; begins a load when sampled high in IDLE or DONE.
- `rxValid`  input  1  one-cycle qualifier for `rxByte`.
- `rxByte`  input  8  incoming stream byte.
- `writeEnable`  output  1  one-cycle write strobe to instruction memory.
- `writeAddress`  output  ADDR_WIDTH  word address for the write.
- `writeData`  output  32  assembled instruction word.
- `loading`  output  1  high in HEADER or DATA.
- `programLoaded`  output  1  image complete and committed.
- `loadError`  output  1  load aborted.

## Operation
- States: IDLE, HEADER, DATA, DONE. All outputs are registered.
- Reset puts the block in IDLE and drives every output to 0. This includes `writeAddress`, `writeData`, and the internal byte index, word count and timeout counter.
- IDLE or DONE, with `startProgramLoading`=1:
  - Go to HEADER.
  - Clear `programLoaded`, `loadError`, byte index, address and timeout counter.
- `rxValid` is ignored in IDLE and DONE.
- `startProgramLoading` is ignored in HEADER and DATA.
- HEADER: collect 4 bytes, MSB first, into the 32-bit count N.
  - N = 0: go to DONE with `programLoaded`=1.
  - N > 2^ADDR_WIDTH: go to DONE with `loadError`=1 and `programLoaded`=0.
  - Otherwise go to DATA with address 0.
- DATA: bytes shift in MSB first; byte index wraps 0 to 3.
  - On the 4th byte, the next cycle drives `writeEnable`=1 with `writeData` = assembled word and `writeAddress` = current address.
  - The address then increments by 1.
  - After word N is written, go to DONE with `programLoaded`=1.
- Timeout: in HEADER or DATA, the counter increments on every cycle with `rxValid`=0 and clears on `rxValid`=1.
  - On reaching TIMEOUT_CYCLES, go to DONE with `loadError`=1.
  - A word still being assembled is discarded. No partial write occurs.
- `programLoaded` and `loadError` hold until the next start or reset. They are never both 1.
- Address arithmetic is ADDR_WIDTH bits. A full-capacity load (N = 2^ADDR_WIDTH) writes through address 2^ADDR_WIDTH−1 and never wraps to re-write address 0.

## Timing
- `startProgramLoading` sampled at cycle t: state is HEADER and `loading`=1 at t+1. A byte presented at t+1 is accepted.
- Back-to-back bytes on consecutive cycles are accepted indefinitely. There is no backpressure.
- 4th byte of a word at cycle t:
  - `writeEnable` is high during t+1 only.
  - A byte arriving at t+1 is accepted as byte 0 of the next word.
- Final word, 4th byte at t:
  - Last `writeEnable` at t+1.
  - State DONE and `loading`=0 at t+1.
  - `programLoaded`=1 at t+2, one cycle after the last write, so the write is committed first.
- Header-terminated loads (N=0 or oversize), 4th header byte at t:
  - DONE, `loading`=0 at t+1.
  - `programLoaded` or `loadError` = 1 at t+2.
- Timeout: the flag rises 2 cycles after the counter reaches TIMEOUT_CYCLES, consistent with the above.
- `reset` high at any cycle, including mid-word or coincident with a write:
  - All outputs are 0 the next cycle.
  - A pending write strobe is suppressed.
- `startProgramLoading` held high through DONE re-arms immediately. This is intended; callers pulse it.

## Test plan
- Reset, then start; stream N=3 (00 00 00 03) followed by 12 bytes for 0x20080005, 0x21290001, 0xAC090000, one byte per cycle -> three `writeEnable` pulses at addresses 0, 1, 2 with those data; `programLoaded`=1 exactly 1 cycle after the third pulse.
- Header N=0 -> no `writeEnable`; `programLoaded`=1 two cycles after the 4th header byte; `loadError`=0.
- ADDR_WIDTH=4, header N=17 -> `loadError`=1, `programLoaded`=0, no writes; header N=16 with 64 bytes -> writes to addresses 0..15, no write to 0 afterwards, `programLoaded`=1.
- TIMEOUT_CYCLES=8, N=2, stop after 6 data bytes -> exactly one write (address 0), `loadError`=1 after 8 idle cycles, no second write; restart with start pulse clears `loadError` and address returns to 0.
- Bytes with random gaps (0–5 idle cycles, below timeout) for N=4 -> same writes as the gapless stream; `rxValid` pulses in IDLE/DONE produce no writes.
- Assert `reset` on the cycle a 4th data byte arrives -> no `writeEnable` follows; all outputs 0; subsequent start plus full stream loads correctly from address 0.

Source files
------------

// File: rtl/program_loader.sv
// rtl/program_loader.sv - length-prefixed byte-stream loader that writes 32-bit words to instruction memory
module program_loader #(
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  startProgramLoading,
  input  logic                  rxValid,
  input  logic [7:0]            rxByte,
  output logic                  writeEnable,
  output logic [ADDR_WIDTH-1:0] writeAddress,
  output logic [31:0]           writeData,
  output logic                  loading,
  output logic                  programLoaded,
  output logic                  loadError
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]       TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [32:0]         CAPACITY = 33'(1) << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] ONE_W    = 1;

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_DATA, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [23:0]           sh_q, sh_d;
  logic [ADDR_WIDTH:0]   n_q, n_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  pend_ok_q, pend_ok_d;
  logic                  pend_err_q, pend_err_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  loading_q, loading_d;
  logic                  loaded_q, loaded_d;
  logic                  err_q, err_d;

  logic [31:0] word;
  logic [32:0] hdr_n;

  always_comb begin
    word       = {sh_q, rxByte};
    hdr_n      = {1'b0, word};
    state_d    = state_q;
    idx_d      = idx_q;
    sh_d       = sh_q;
    n_d        = n_q;
    addr_d     = addr_q;
    tmo_d      = tmo_q;
    pend_ok_d  = 1'b0;
    pend_err_d = 1'b0;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    loading_d  = loading_q;
    loaded_d   = loaded_q;
    err_d      = err_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        // Flags land one cycle after entering DONE so the last write commits first.
        if (pend_ok_q)  loaded_d = 1'b1;
        if (pend_err_q) err_d    = 1'b1;
        if (startProgramLoading) begin
          state_d   = S_HEADER;
          loading_d = 1'b1;
          loaded_d  = 1'b0;
          err_d     = 1'b0;
          idx_d     = '0;
          addr_d    = '0;
          waddr_d   = '0;
          tmo_d     = '0;
        end
      end
      S_HEADER, S_DATA: begin
        if (rxValid) begin
          tmo_d = '0;
          sh_d  = word[23:0];
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            if (state_q == S_HEADER) begin
              if (hdr_n == 33'd0) begin
                state_d   = S_DONE;
                loading_d = 1'b0;
                pend_ok_d = 1'b1;
              end else if (hdr_n > CAPACITY) begin
                state_d    = S_DONE;
                loading_d  = 1'b0;
                pend_err_d = 1'b1;
              end else begin
                state_d = S_DATA;
                n_d     = hdr_n[ADDR_WIDTH:0];
                addr_d  = '0;
              end
            end else begin
              we_d    = 1'b1;
              wdata_d = word;
              waddr_d = addr_q;
              addr_d  = addr_q + 1'b1;
              if (({1'b0, addr_q} + ONE_W) == n_q) begin
                state_d   = S_DONE;
                loading_d = 1'b0;
                pend_ok_d = 1'b1;
              end
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          // Any partially assembled word is simply dropped.
          state_d    = S_DONE;
          loading_d  = 1'b0;
          pend_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      sh_q       <= '0;
      n_q        <= '0;
      addr_q     <= '0;
      tmo_q      <= '0;
      pend_ok_q  <= 1'b0;
      pend_err_q <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      loading_q  <= 1'b0;
      loaded_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      sh_q       <= sh_d;
      n_q        <= n_d;
      addr_q     <= addr_d;
      tmo_q      <= tmo_d;
      pend_ok_q  <= pend_ok_d;
      pend_err_q <= pend_err_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      loading_q  <= loading_d;
      loaded_q   <= loaded_d;
      err_q      <= err_d;
    end
  end

  assign writeEnable   = we_q;
  assign writeAddress  = waddr_q;
  assign writeData     = wdata_q;
  assign loading       = loading_q;
  assign programLoaded = loaded_q;
  assign loadError     = err_q;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - self-checking bench for program_loader (ADDR_WIDTH=4, TIMEOUT_CYCLES=8)
module tb_program_loader;
  localparam int AW  = 4;
  localparam int TMO = 8;
  localparam int CAP = 1 << AW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          startProgramLoading = 1'b0;
  logic          rxValid = 1'b0;
  logic [7:0]    rxByte = 8'h00;
  logic          writeEnable;
  logic [AW-1:0] writeAddress;
  logic [31:0]   writeData;
  logic          loading;
  logic          programLoaded;
  logic          loadError;

  program_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset), .startProgramLoading(startProgramLoading),
    .rxValid(rxValid), .rxByte(rxByte), .writeEnable(writeEnable),
    .writeAddress(writeAddress), .writeData(writeData), .loading(loading),
    .programLoaded(programLoaded), .loadError(loadError)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int          compared = 0;
  int          mismatched = 0;
  int          wq_addr[$];
  logic [31:0] wq_data[$];
  int          wq_cyc[$];
  int          pl_rise = -1;
  int          le_rise = -1;
  logic        pl_prev = 1'b0;
  logic        le_prev = 1'b0;
  int          both_bad = 0;
  int          last_cyc = 0;

  // Observes the write port and flag edges away from the active edge.
  always @(negedge clock) begin
    if (writeEnable) begin
      wq_addr.push_back(int'(writeAddress));
      wq_data.push_back(writeData);
      wq_cyc.push_back(cyc);
    end
    if (programLoaded && !pl_prev) pl_rise = cyc;
    if (loadError && !le_prev) le_rise = cyc;
    pl_prev = programLoaded;
    le_prev = loadError;
    if (programLoaded && loadError) both_bad++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) step();
    rxValid = 1'b1;
    rxByte  = b;
    step();
    rxValid  = 1'b0;
    last_cyc = cyc;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], $urandom_range(0, max_gap));
  endtask

  task automatic start_load();
    startProgramLoading = 1'b1;
    step();
    startProgramLoading = 1'b0;
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
    pl_rise = -1;
    le_rise = -1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"}, writeEnable, 0);
    chk({tag, "_addr"}, writeAddress, 0);
    chk({tag, "_data"}, writeData, 0);
    chk({tag, "_loading"}, loading, 0);
    chk({tag, "_loaded"}, programLoaded, 0);
    chk({tag, "_err"}, loadError, 0);
  endtask

  typedef struct {
    logic [31:0] hdr;
    int          nbytes;
    int          max_gap;
    int          exp_writes;
    logic        exp_loaded;
    logic        exp_error;
  } vec_t;

  initial begin
    vec_t        vecs[$];
    logic [31:0] spec_words[3];
    logic [7:0]  bq[$];
    int          exp_words;
    int          budget;
    int          n_before;

    vecs.push_back('{32'd4,          16, 5, 4,  1'b1, 1'b0});
    vecs.push_back('{32'd3,          12, 0, 3,  1'b1, 1'b0});
    vecs.push_back('{32'd0,          0,  3, 0,  1'b1, 1'b0});
    vecs.push_back('{32'd17,         0,  0, 0,  1'b0, 1'b1});
    vecs.push_back('{32'd16,         64, 0, 16, 1'b1, 1'b0});
    vecs.push_back('{32'd1,          4,  4, 1,  1'b1, 1'b0});
    vecs.push_back('{32'd2,          6,  0, 1,  1'b0, 1'b1});
    vecs.push_back('{32'd5,          9,  2, 2,  1'b0, 1'b1});
    vecs.push_back('{32'h0100_0000,  0,  1, 0,  1'b0, 1'b1});
    vecs.push_back('{32'd16,         64, 3, 16, 1'b1, 1'b0});
    spec_words[0] = 32'h2008_0005;
    spec_words[1] = 32'h2129_0001;
    spec_words[2] = 32'hAC09_0000;

    repeat (3) step();
    chk_all_zero("reset");
    reset = 1'b0;
    step();

    for (int k = 0; k < 3; k++) send_byte(8'h5A, 0);
    step();
    chk("idle_rx_nwr", wq_addr.size(), 0);
    chk("idle_rx_loading", loading, 0);

    // Reference stream N=3 with exact strobe and flag timing.
    start_load();
    chk("start_loading", loading, 1);
    send_word(32'd3, 0);
    for (int i = 0; i < 3; i++) send_word(spec_words[i], 0);
    chk("last_we", writeEnable, 1);
    chk("last_loading", loading, 0);
    chk("last_loaded_not_yet", programLoaded, 0);
    repeat (3) step();
    chk("ref_nwr", wq_addr.size(), 3);
    for (int i = 0; i < wq_addr.size() && i < 3; i++) begin
      chk($sformatf("ref_addr%0d", i), wq_addr[i], i);
      chk($sformatf("ref_data%0d", i), wq_data[i], spec_words[i]);
    end
    if (wq_cyc.size() == 3) chk("ref_loaded_lat", pl_rise, wq_cyc[2] + 1);
    chk("ref_err", loadError, 0);

    // Empty image.
    start_load();
    chk("n0_cleared", programLoaded, 0);
    send_word(32'd0, 0);
    chk("n0_loading", loading, 0);
    repeat (3) step();
    chk("n0_lat", pl_rise, last_cyc + 1);
    chk("n0_nwr", wq_addr.size(), 0);
    chk("n0_err", loadError, 0);

    // Stall after six data bytes.
    start_load();
    send_word(32'd2, 0);
    send_word(32'h1122_3344, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    repeat (14) step();
    chk("tmo_nwr", wq_addr.size(), 1);
    if (wq_addr.size() > 0) chk("tmo_addr0", wq_addr[0], 0);
    chk("tmo_lat", le_rise, last_cyc + TMO + 1);
    chk("tmo_err", loadError, 1);
    chk("tmo_loaded", programLoaded, 0);
    start_load();
    chk("restart_err_clr", loadError, 0);
    chk("restart_addr0", writeAddress, 0);
    chk("restart_loading", loading, 1);
    repeat (TMO + 4) step();

    // Reset landing on the 4th data byte.
    start_load();
    send_word(32'd2, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    send_byte(8'h03, 0);
    rxValid = 1'b1;
    rxByte  = 8'h04;
    reset   = 1'b1;
    step();
    rxValid = 1'b0;
    reset   = 1'b0;
    chk_all_zero("rst_mid");
    step();
    chk("rst_mid_we_after", writeEnable, 0);
    chk("rst_mid_nwr", wq_addr.size(), 0);

    // Randomized table-driven loads checked against a byte-level model.
    for (int v = 0; v < vecs.size(); v++) begin
      start_load();
      send_word(vecs[v].hdr, vecs[v].max_gap);
      bq.delete();
      for (int j = 0; j < vecs[v].nbytes; j++) bq.push_back(8'($urandom_range(0, 255)));
      foreach (bq[j]) send_byte(bq[j], $urandom_range(0, vecs[v].max_gap));
      budget = 0;
      while (!(programLoaded || loadError) && budget < 40) begin
        step();
        budget++;
      end
      chk($sformatf("v%0d_in_budget", v), budget < 40, 1);
      n_before = wq_addr.size();
      send_byte(8'hA5, 0);
      send_byte(8'h5A, 1);
      repeat (3) step();
      chk($sformatf("v%0d_done_rx_nwr", v), wq_addr.size(), n_before);
      if (vecs[v].hdr > 32'(CAP)) exp_words = 0;
      else if (vecs[v].nbytes / 4 < int'(vecs[v].hdr)) exp_words = vecs[v].nbytes / 4;
      else exp_words = int'(vecs[v].hdr);
      chk($sformatf("v%0d_nwr", v), wq_addr.size(), vecs[v].exp_writes);
      for (int i = 0; i < wq_addr.size() && i < exp_words; i++) begin
        chk($sformatf("v%0d_addr%0d", v, i), wq_addr[i], i);
        chk($sformatf("v%0d_data%0d", v, i), wq_data[i],
            {bq[4*i], bq[4*i+1], bq[4*i+2], bq[4*i+3]});
      end
      chk($sformatf("v%0d_loaded", v), programLoaded, vecs[v].exp_loaded);
      chk($sformatf("v%0d_err", v), loadError, vecs[v].exp_error);
      chk($sformatf("v%0d_loading", v), loading, 0);
    end

    chk("flags_exclusive", both_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
